// File: rtl/reg_bus_master.sv
// reg_bus_master: register-bus initiator for host write, read-burst and poll
// commands; one bus transaction in flight, results on a valid/ready stream.
module reg_bus_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int POLL_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [7:0]            cmd_len,
  output logic                  reg_ce,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAP,
    RSP
  } state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  state_t                state;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [7:0]            beat_q;
  logic [7:0]            poll_q;
  logic                  hit;

  assign hit = |(reg_rdata & mask_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      reg_ce    <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      op_q      <= '0;
      mask_q    <= '0;
      beat_q    <= '0;
      poll_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            op_q      <= cmd_op;
            mask_q    <= cmd_data;
            beat_q    <= cmd_len;
            poll_q    <= '0;
            unique case (1'b1)
              (cmd_op == OP_WR): begin
                state     <= WR;
                reg_ce    <= 1'b1;
                reg_we    <= 1'b1;
                reg_addr  <= cmd_addr;
                reg_wdata <= cmd_data;
              end
              (cmd_op == OP_RD),
              (cmd_op == OP_POLL): begin
                state    <= RD_ISSUE;
                reg_ce   <= 1'b1;
                reg_we   <= 1'b0;
                reg_addr <= cmd_addr;
              end
              default: begin
                state     <= RSP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          reg_ce    <= 1'b0;
          reg_we    <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        RD_ISSUE: begin
          reg_ce <= 1'b0;
          state  <= RD_CAP;
        end
        RD_CAP: begin
          if ((op_q == OP_RD) || hit) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_data  <= reg_rdata;
            rsp_err   <= 1'b0;
          end else if (poll_q == POLL_LAST) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_data  <= reg_rdata;
            rsp_err   <= 1'b1;
          end else begin
            poll_q <= poll_q + 8'd1;
            state  <= RD_ISSUE;
            reg_ce <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if ((op_q == OP_RD) && (beat_q != 8'd0)) begin
              beat_q <= beat_q - 8'd1;
              state  <= RD_ISSUE;
              reg_ce <= 1'b1;
              reg_we <= 1'b0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: randomized commands against a
// command-level model of strobes and responses.
module tb_reg_bus_master;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PM = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [7:0]    cmd_len;
  logic          reg_ce, reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err, busy;

  always #5 clk = ~clk;

  reg_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } strobe_t;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } rsp_t;

  strobe_t     strobes[$];
  rsp_t        rsps[$];
  rsp_t        exp_rsps[$];
  int          rsp_rise[$];
  logic [15:0] rd_src[$];

  int          cyc = 0, nchk = 0, nfail = 0;
  int          acc_cyc, exp_n, bp_err, stab_err, hold_cnt, hold_beat;
  bit          accepted, rd_pend, prev_stall, prev_valid, bp_rand, rdy_a1;
  logic [15:0] prev_data;
  logic        prev_err;

  task automatic tick();
    @(negedge clk);
    if (reg_ce) begin
      strobes.push_back({32'(cyc), reg_we, reg_addr, reg_wdata});
      rd_pend = !reg_we;
      if (rsp_valid || prev_stall) bp_err++;
    end
    if (prev_stall && (!rsp_valid || rsp_data !== prev_data || rsp_err !== prev_err))
      stab_err++;
    if (rsp_valid && !prev_valid) rsp_rise.push_back(cyc);
    if (rsp_valid && rsp_ready) rsps.push_back({rsp_err, rsp_data});
    if (cmd_valid && cmd_ready) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_valid = rsp_valid;
    prev_data  = rsp_data;
    prev_err   = rsp_err;
    @(posedge clk);
    cyc++;
    if (rd_pend) begin
      reg_rdata = (rd_src.size() > 0) ? rd_src.pop_front() : 16'h0;
      rd_pend = 1'b0;
    end
    #1;
    if (hold_cnt > 0 && rsps.size() == hold_beat) begin
      rsp_ready = 1'b0;
      if (rsp_valid) hold_cnt--;
    end else begin
      rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  function automatic logic [15:0] src_at(input int i);
    return (i < rd_src.size()) ? rd_src[i] : 16'h0;
  endfunction

  task automatic model(input logic [1:0] op, input logic [15:0] mask,
                       input logic [7:0] len);
    logic [15:0] v;
    exp_rsps.delete();
    exp_n = 0;
    case (op)
      2'd0: exp_n = 1;
      2'd1: for (int i = 0; i <= int'(len); i++) begin
        exp_n++;
        exp_rsps.push_back({1'b0, src_at(i)});
      end
      2'd2: for (int i = 0; i < PM; i++) begin
        v = src_at(i);
        exp_n++;
        if ((v & mask) != 16'h0) begin
          exp_rsps.push_back({1'b0, v});
          break;
        end
        if (i == PM - 1) exp_rsps.push_back({1'b1, v});
      end
      default: exp_rsps.push_back({1'b1, 16'h0});
    endcase
  endtask

  function automatic int strobes_off(input logic [7:0] a, input logic we);
    int n = (strobes.size() == exp_n) ? 0 : 1;
    foreach (strobes[i])
      if (strobes[i].addr !== a || strobes[i].we !== we) n++;
    return n;
  endfunction

  function automatic int rsps_off();
    int n = (rsps.size() == exp_rsps.size()) ? 0 : 1;
    foreach (rsps[i])
      if (i < exp_rsps.size() && rsps[i] !== exp_rsps[i]) n++;
    return n;
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] a,
                      input logic [15:0] d, input logic [7:0] len);
    int k = 0;
    strobes.delete(); rsps.delete(); rsp_rise.delete();
    bp_err = 0; stab_err = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_len = len;
    cmd_valid = 1'b1; accepted = 1'b0;
    while (!accepted && k < 50) begin
      tick();
      k++;
    end
    rdy_a1 = cmd_ready;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 8'($urandom);
    cmd_data = 16'($urandom); cmd_len = 8'($urandom);
  endtask

  task automatic exec(input logic [1:0] op, input logic [7:0] a,
                      input logic [15:0] d, input logic [7:0] len,
                      output bit ok);
    int k = 0;
    model(op, d, len);
    send(op, a, d, len);
    while ((rsps.size() < exp_rsps.size() || busy) && k < 5000) begin
      tick();
      k++;
    end
    ok = accepted && (k < 5000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({cmd_ready, reg_ce, reg_we, reg_addr, reg_wdata, rsp_valid,
         rsp_data, rsp_err, busy} !== '0) begin
      nfail++;
      $display("FAIL reset_values got=%b exp=0", {cmd_ready, reg_ce, reg_we,
               reg_addr, reg_wdata, rsp_valid, rsp_data, rsp_err, busy});
    end
    rst = 1'b0;
    tick();
    nchk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_ready got=%b%b exp=10", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] a;
    logic [15:0] d;
    strobe_t e;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 8'h10 : 8'($urandom);
      d = (n == 0) ? 16'h0215 : 16'($urandom);
      exec(2'd0, a, d, 8'($urandom), ok);
      e = {32'(acc_cyc + 1), 1'b1, a, d};
      nchk++;
      if (!ok || rdy_a1 !== 1'b0) begin
        nfail++;
        $display("FAIL wr_accept got=%0d/%0d exp=1/0", ok, rdy_a1);
      end
      nchk++;
      if (strobes.size() != 1 || strobes[0] !== e) begin
        nfail++;
        $display("FAIL wr_strobe got=%0d:%h exp=1:%h", strobes.size(),
                 (strobes.size() > 0) ? strobes[0] : '0, e);
      end
      nchk++;
      if (rsp_rise.size() != 0) begin
        nfail++;
        $display("FAIL wr_no_rsp got=%0d exp=0", rsp_rise.size());
      end
      nchk++;
      if (cmd_ready !== 1'b1 || cyc != acc_cyc + 2) begin
        nfail++;
        $display("FAIL wr_ready_again got=%b@%0d exp=1@%0d",
                 cmd_ready, cyc - acc_cyc, 2);
      end
    end
  endtask

  task automatic test_read();
    bit ok;
    logic [7:0] a;
    logic [7:0] len;
    int gap_bad;
    rd_src = '{16'h0215};
    exec(2'd1, 8'h10, 16'($urandom), 8'd0, ok);
    nchk++;
    if (!ok || strobes_off(8'h10, 1'b0) != 0 || strobes[0].cyc != acc_cyc + 1) begin
      nfail++;
      $display("FAIL rd_strobe got=%0d strobes exp=1", strobes.size());
    end
    nchk++;
    if (rsp_rise.size() != 1 || rsp_rise[0] != acc_cyc + 3) begin
      nfail++;
      $display("FAIL rd_latency got=%0d exp=3",
               (rsp_rise.size() > 0) ? rsp_rise[0] - acc_cyc : -1);
    end
    nchk++;
    if (rsps_off() != 0) begin
      nfail++;
      $display("FAIL rd_data got=%h exp=%h",
               (rsps.size() > 0) ? rsps[0] : '0, exp_rsps[0]);
    end
    for (int n = 0; n < 4; n++) begin
      a = 8'($urandom);
      len = 8'($urandom_range(1, 5));
      rd_src.delete();
      for (int i = 0; i <= int'(len); i++) rd_src.push_back(16'($urandom));
      exec(2'd1, a, 16'h0, len, ok);
      gap_bad = 0;
      for (int i = 1; i < strobes.size(); i++)
        if (strobes[i].cyc != strobes[i-1].cyc + 3) gap_bad++;
      nchk++;
      if (!ok || strobes_off(a, 1'b0) != 0 || gap_bad != 0) begin
        nfail++;
        $display("FAIL rd_burst_strobes got=%0d gapbad=%0d exp=%0d",
                 strobes.size(), gap_bad, exp_n);
      end
      nchk++;
      if (rsps_off() != 0) begin
        nfail++;
        $display("FAIL rd_burst_data got=%0d rsps exp=%0d", rsps.size(),
                 exp_rsps.size());
      end
    end
  endtask

  task automatic test_burst_bp();
    bit ok;
    logic [7:0] a;
    logic [7:0] len;
    rd_src = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    hold_cnt = 5;
    hold_beat = 1;
    exec(2'd1, 8'h38, 16'h0, 8'd3, ok);
    nchk++;
    if (!ok || strobes_off(8'h38, 1'b0) != 0) begin
      nfail++;
      $display("FAIL bp_strobes got=%0d exp=4", strobes.size());
    end
    nchk++;
    if (rsps_off() != 0) begin
      nfail++;
      $display("FAIL bp_order got=%0d rsps exp=4", rsps.size());
    end
    nchk++;
    if (bp_err != 0 || stab_err != 0) begin
      nfail++;
      $display("FAIL bp_hold got=%0d/%0d exp=0/0", bp_err, stab_err);
    end
    nchk++;
    if (strobes.size() < 3 || strobes[2].cyc != strobes[1].cyc + 8) begin
      nfail++;
      $display("FAIL bp_stall_gap got=%0d exp=8",
               (strobes.size() > 2) ? strobes[2].cyc - strobes[1].cyc : 0);
    end
    bp_rand = 1'b1;
    for (int n = 0; n < 6; n++) begin
      a = 8'($urandom);
      len = 8'($urandom_range(0, 9));
      rd_src.delete();
      for (int i = 0; i <= int'(len); i++) rd_src.push_back(16'($urandom));
      exec(2'd1, a, 16'h0, len, ok);
      nchk++;
      if (!ok || strobes_off(a, 1'b0) != 0 || rsps_off() != 0 ||
          bp_err != 0 || stab_err != 0) begin
        nfail++;
        $display("FAIL bp_rand got=%0d/%0d bp=%0d st=%0d exp=%0d",
                 strobes.size(), rsps.size(), bp_err, stab_err, exp_n);
      end
    end
    bp_rand = 1'b0;
    rd_src.delete();
    for (int i = 0; i < 256; i++) rd_src.push_back(16'($urandom));
    exec(2'd1, 8'hFF, 16'h0, 8'd255, ok);
    nchk++;
    if (!ok || strobes_off(8'hFF, 1'b0) != 0 || rsps_off() != 0) begin
      nfail++;
      $display("FAIL burst_256 got=%0d/%0d exp=256", strobes.size(), rsps.size());
    end
  endtask

  task automatic test_poll();
    bit ok;
    int gap_bad;
    logic [15:0] mask;
    rd_src = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0002};
    exec(2'd2, 8'h00, 16'h0002, 8'($urandom), ok);
    gap_bad = 0;
    for (int i = 1; i < strobes.size(); i++)
      if (strobes[i].cyc != strobes[i-1].cyc + 2) gap_bad++;
    nchk++;
    if (!ok || strobes_off(8'h00, 1'b0) != 0 || gap_bad != 0) begin
      nfail++;
      $display("FAIL poll_hit_strobes got=%0d gapbad=%0d exp=5",
               strobes.size(), gap_bad);
    end
    nchk++;
    if (rsps_off() != 0 || exp_rsps[0] !== {1'b0, 16'h0002}) begin
      nfail++;
      $display("FAIL poll_hit_rsp got=%h exp=%h",
               (rsps.size() > 0) ? rsps[0] : '0, {1'b0, 16'h0002});
    end
    rd_src.delete();
    exec(2'd2, 8'h24, 16'h0002, 8'h0, ok);
    nchk++;
    if (!ok || strobes_off(8'h24, 1'b0) != 0 || rsps_off() != 0) begin
      nfail++;
      $display("FAIL poll_timeout got=%0d/%h exp=%0d/%h", strobes.size(),
               (rsps.size() > 0) ? rsps[0] : '0, PM, {1'b1, 16'h0});
    end
    rd_src.delete();
    for (int i = 0; i < PM; i++) rd_src.push_back(16'($urandom) | 16'h1);
    exec(2'd2, 8'h55, 16'h0, 8'h0, ok);
    nchk++;
    if (!ok || strobes_off(8'h55, 1'b0) != 0 || rsps_off() != 0) begin
      nfail++;
      $display("FAIL poll_mask0 got=%0d/%h exp=%0d/%h", strobes.size(),
               (rsps.size() > 0) ? rsps[0] : '0, PM, exp_rsps[0]);
    end
    bp_rand = 1'b1;
    for (int n = 0; n < 8; n++) begin
      mask = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      rd_src.delete();
      for (int i = 0; i < PM; i++)
        rd_src.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0);
      exec(2'd2, 8'h40 + 8'(n), mask, 8'h0, ok);
      nchk++;
      if (!ok || strobes_off(8'h40 + 8'(n), 1'b0) != 0 || rsps_off() != 0) begin
        nfail++;
        $display("FAIL poll_rand got=%0d/%h exp=%0d/%h", strobes.size(),
                 (rsps.size() > 0) ? rsps[0] : '0, exp_n, exp_rsps[0]);
      end
    end
    bp_rand = 1'b0;
  endtask

  task automatic test_reserved();
    bit ok;
    exec(2'd3, 8'h77, 16'hFFFF, 8'h3, ok);
    nchk++;
    if (!ok || strobes.size() != 0 || rsps_off() != 0) begin
      nfail++;
      $display("FAIL reserved got=%0d/%h exp=0/%h", strobes.size(),
               (rsps.size() > 0) ? rsps[0] : '0, {1'b1, 16'h0});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    rd_src = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    send(2'd1, 8'h38, 16'h0, 8'd3);
    while (strobes.size() < 3 && k < 100) begin
      tick();
      k++;
    end
    nchk++;
    if (k >= 100) begin
      nfail++;
      $display("FAIL rst_mid_reach got=%0d exp=3", strobes.size());
    end
    rst = 1'b1;
    #1;
    nchk++;
    if ({cmd_ready, reg_ce, reg_we, reg_addr, reg_wdata, rsp_valid,
         rsp_data, rsp_err, busy} !== '0) begin
      nfail++;
      $display("FAIL rst_mid_values got=%b exp=0", {cmd_ready, reg_ce, reg_we,
               reg_addr, reg_wdata, rsp_valid, rsp_data, rsp_err, busy});
    end
    rd_src.delete();
    rd_pend = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    strobes.delete(); rsps.delete(); rsp_rise.delete();
    tick();
    nchk++;
    if (cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_mid_ready got=%b exp=1", cmd_ready);
    end
    repeat (4) tick();
    nchk++;
    if (rsp_rise.size() != 0 || strobes.size() != 0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mid_stale got=%0d/%0d exp=0/0",
               rsp_rise.size(), strobes.size());
    end
    rd_src = '{16'h1234};
    exec(2'd1, 8'h21, 16'h0, 8'd0, ok);
    nchk++;
    if (!ok || strobes_off(8'h21, 1'b0) != 0 || rsps_off() != 0) begin
      nfail++;
      $display("FAIL rst_mid_recover got=%0d/%0d exp=1/1",
               strobes.size(), rsps.size());
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
    cmd_len = '0; reg_rdata = '0; rsp_ready = 1'b1;
    bp_rand = 1'b0; hold_cnt = 0; hold_beat = 0; rd_pend = 1'b0;
    prev_stall = 1'b0; prev_valid = 1'b0; prev_data = '0; prev_err = 1'b0;
    acc_cyc = 0; exp_n = 0; bp_err = 0; stab_err = 0; accepted = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_burst_bp();
    test_poll();
    test_reserved();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #2ms;
    nfail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
